// File: rtl/cnt_pkg.sv
// Shared types and constants for the multi-mode counter.
package cnt_pkg;

  // Counting mode selected by mode_i
  typedef enum logic [1:0] {
    CNT_UP     = 2'd0,
    CNT_DOWN   = 2'd1,
    CNT_UPDOWN = 2'd2,
    CNT_HOLD   = 2'd3
  } cnt_mode_e;

  // Encoding of dir_o
  localparam logic CNT_DIR_UP   = 1'b0;
  localparam logic CNT_DIR_DOWN = 1'b1;

endpackage

// File: rtl/cnt_prescaler.sv
// Tick divider: asserts tick_o once every prescale_i+1 enabled cycles.
// The cycle count is retained while en_i is low and cleared by clear_i.
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] presc_r;
  logic                  hit_s;

  assign hit_s  = (presc_r == prescale_i);
  assign tick_o = en_i & hit_s & ~clear_i;

  // Enabled-cycle counter, restarts after every tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_r <= PRESC_ZERO;
    end else if (clear_i) begin
      presc_r <= PRESC_ZERO;
    end else if (en_i) begin
      if (hit_s) begin
        presc_r <= PRESC_ZERO;
      end else begin
        presc_r <= presc_r + PRESC_ONE;
      end
    end else begin
      presc_r <= presc_r;
    end
  end

endmodule

// File: rtl/cnt_multimode.sv
// Multi-mode counter: up, down or triangle, wrap or saturate, with prescaler,
// synchronous load, programmable upper terminal and terminal-count pulse.
// Optional capture port enabled by defining CNT_CAPTURE_EN.
module cnt_multimode
  import cnt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic                  sat_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      max_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  dir_o,
  output logic                  tc_o
`ifdef CNT_CAPTURE_EN
  ,
  input  logic                  cap_i,
  output logic [WIDTH-1:0]      cap_o,
  output logic                  cap_valid_o
`endif
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_mode_e        mode_s;
  logic             tick_s;
  logic             max_zero_s;
  logic [WIDTH-1:0] cnt_r;
  logic             dir_r;
  logic             tc_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             dir_nxt_s;
  logic             tc_nxt_s;

  assign mode_s     = cnt_mode_e'(mode_i);
  assign max_zero_s = (max_i == CNT_ZERO);

  // Load restarts the prescaler so the next tick is a full period away
  cnt_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .clear_i    (load_i),
    .prescale_i (prescale_i),
    .tick_o     (tick_s)
  );

  // Next count/direction/terminal pulse; load has priority over a tick
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    tc_nxt_s  = 1'b0;
    if (load_i) begin
      cnt_nxt_s = load_val_i;
      case (mode_s)
        CNT_UP:   dir_nxt_s = CNT_DIR_UP;
        CNT_DOWN: dir_nxt_s = CNT_DIR_DOWN;
        default:  dir_nxt_s = dir_r;
      endcase
    end else if (tick_s) begin
      case (mode_s)
        CNT_UP: begin
          dir_nxt_s = CNT_DIR_UP;
          // A count above max is treated as already terminal
          if (cnt_r >= max_i) begin
            cnt_nxt_s = sat_i ? max_i : CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
          // Pulse on arrival at max, not while sitting there saturated
          tc_nxt_s = (cnt_nxt_s == max_i) && ((cnt_r != cnt_nxt_s) || max_zero_s);
        end
        CNT_DOWN: begin
          dir_nxt_s = CNT_DIR_DOWN;
          if (cnt_r == CNT_ZERO) begin
            cnt_nxt_s = sat_i ? CNT_ZERO : max_i;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
          tc_nxt_s = (cnt_nxt_s == CNT_ZERO) && ((cnt_r != CNT_ZERO) || max_zero_s);
        end
        CNT_UPDOWN: begin
          if (max_zero_s) begin
            cnt_nxt_s = CNT_ZERO;
            tc_nxt_s  = 1'b1;
          end else if (cnt_r > max_i) begin
            cnt_nxt_s = max_i;
            dir_nxt_s = CNT_DIR_DOWN;
            tc_nxt_s  = 1'b1;
          end else begin
            if (dir_r == CNT_DIR_UP) begin
              cnt_nxt_s = (cnt_r == max_i) ? (max_i - CNT_ONE) : (cnt_r + CNT_ONE);
            end else begin
              cnt_nxt_s = (cnt_r == CNT_ZERO) ? CNT_ONE : (cnt_r - CNT_ONE);
            end
            // dir_o always shows the direction the following tick will take
            if (cnt_nxt_s == max_i) begin
              dir_nxt_s = CNT_DIR_DOWN;
              tc_nxt_s  = 1'b1;
            end else if (cnt_nxt_s == CNT_ZERO) begin
              dir_nxt_s = CNT_DIR_UP;
              tc_nxt_s  = 1'b1;
            end else if (cnt_r == max_i) begin
              dir_nxt_s = CNT_DIR_DOWN;
            end else if (cnt_r == CNT_ZERO) begin
              dir_nxt_s = CNT_DIR_UP;
            end else begin
              dir_nxt_s = dir_r;
            end
          end
        end
        CNT_HOLD: begin
          cnt_nxt_s = cnt_r;
          dir_nxt_s = dir_r;
        end
        default: begin
          cnt_nxt_s = cnt_r;
          dir_nxt_s = dir_r;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
      dir_nxt_s = dir_r;
    end
  end

  // Count, direction and terminal-count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= CNT_ZERO;
      dir_r <= CNT_DIR_UP;
      tc_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      dir_r <= dir_nxt_s;
      tc_r  <= tc_nxt_s;
    end
  end

  assign cnt_o = cnt_r;
  assign dir_o = dir_r;
  assign tc_o  = tc_r;

`ifdef CNT_CAPTURE_EN
  logic [WIDTH-1:0] cap_r;
  logic             cap_valid_r;

  // Snapshot of the count as it stood before this edge's update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_r       <= CNT_ZERO;
      cap_valid_r <= 1'b0;
    end else if (cap_i) begin
      cap_r       <= cnt_r;
      cap_valid_r <= 1'b1;
    end else begin
      cap_r       <= cap_r;
      cap_valid_r <= 1'b0;
    end
  end

  assign cap_o       = cap_r;
  assign cap_valid_o = cap_valid_r;
`endif

endmodule
